// File: rtl/otter_fetch_queue.sv
// OTTER instruction fetch stage: owns the fetch PC, issues reads to memory port 1,
// and buffers returned words with their PCs in a small prefetch ring for decode.
module otter_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    output logic [31:0]            IMEM_ADDR,
    output logic                   IMEM_RD,
    input  logic [31:0]            IMEM_DOUT,
    input  logic                   REDIRECT,
    input  logic [31:0]            REDIRECT_PC,
    input  logic                   ID_READY,
    output logic                   ID_VALID,
    output logic [31:0]            ID_IR,
    output logic [31:0]            ID_PC,
    output logic [$clog2(DEPTH):0] Q_COUNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic          inflight_reg, inflight_next;
    logic [31:0]   inflight_pc_reg, inflight_pc_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic [31:0]   ir_vec [DEPTH];
    logic [31:0]   pc_vec [DEPTH];

    logic          issue;
    logic          enq;
    logic          deq;
    logic [CW-1:0] occupancy;

    // The outstanding read reserves a slot, so a full ring can never be overrun.
    assign occupancy = count_reg + CW'(inflight_reg);
    assign issue     = RESET_N && !REDIRECT && (occupancy < DEPTH_C);
    assign enq       = inflight_reg && !REDIRECT;
    assign ID_VALID  = RESET_N && !REDIRECT && (count_reg != '0);
    assign deq       = ID_VALID && ID_READY;

    assign IMEM_ADDR = fetch_pc_reg;
    assign IMEM_RD   = issue;
    assign ID_IR     = ir_vec[rd_ptr_reg];
    assign ID_PC     = pc_vec[rd_ptr_reg];
    assign Q_COUNT   = count_reg;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = issue;
        inflight_pc_next = inflight_pc_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        if (REDIRECT) begin
            // Everything younger than the redirecting instruction is discarded.
            fetch_pc_next = {REDIRECT_PC[31:2], 2'b00};
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (issue) begin
                fetch_pc_next    = fetch_pc_reg + 32'd4;
                inflight_pc_next = fetch_pc_reg;
            end
            if (enq) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (deq) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            count_next = count_reg + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            fetch_pc_reg    <= RESET_VEC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= RESET_VEC;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
        end
    end

    // Ring storage; entries need no reset since count gates visibility.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [31:0] ir_reg;
        logic [31:0] pc_reg;

        always_ff @(posedge CLK) begin
            if (enq && (wr_ptr_reg == AW'(gi))) begin
                ir_reg <= IMEM_DOUT;
                pc_reg <= inflight_pc_reg;
            end
        end

        assign ir_vec[gi] = ir_reg;
        assign pc_vec[gi] = pc_reg;
    end

    count_in_range: assert property (@(posedge CLK) disable iff (!RESET_N) count_reg <= DEPTH_C);

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue: scoreboard of expected fetch PCs plus
// cycle-exact checks of reset, backpressure, redirect and PC wrap behaviour.
module tb_otter_fetch_queue;
    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset_n, redirect, id_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_dout, id_ir, id_pc;
    logic        imem_rd, id_valid;
    logic [2:0]  q_count;

    logic        reset2_n, redirect2, id2_ready;
    logic [31:0] redirect2_pc;
    logic [31:0] imem2_addr, imem2_dout, id2_ir, id2_pc;
    logic        imem2_rd, id2_valid;
    logic [2:0]  q2_count;

    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    int          delivered2 = 0;
    int          d0;
    logic [31:0] sb[$];
    logic [31:0] sb2[$];

    otter_fetch_queue #(.DEPTH(4), .RESET_VEC(32'h0000_0000)) u_dut (
        .CLK(CLK), .RESET_N(reset_n),
        .IMEM_ADDR(imem_addr), .IMEM_RD(imem_rd), .IMEM_DOUT(imem_dout),
        .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .ID_READY(id_ready), .ID_VALID(id_valid), .ID_IR(id_ir), .ID_PC(id_pc),
        .Q_COUNT(q_count)
    );

    otter_fetch_queue #(.DEPTH(4), .RESET_VEC(32'hFFFF_FFF8)) u_wrap (
        .CLK(CLK), .RESET_N(reset2_n),
        .IMEM_ADDR(imem2_addr), .IMEM_RD(imem2_rd), .IMEM_DOUT(imem2_dout),
        .REDIRECT(redirect2), .REDIRECT_PC(redirect2_pc),
        .ID_READY(id2_ready), .ID_VALID(id2_valid), .ID_IR(id2_ir), .ID_PC(id2_pc),
        .Q_COUNT(q2_count)
    );

    // Memory content is a scramble of the address so IR and PC differ.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge CLK) begin
        imem_dout  <= imem_rd  ? memf(imem_addr)  : 32'hDEAD_BEEF;
        imem2_dout <= imem2_rd ? memf(imem2_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic sb2_restart(input logic [31:0] start);
        sb2.delete();
        for (int i = 0; i < 6; i++) sb2.push_back(start + 32'(4 * i));
    endtask

    // Called at posedge+1; samples at posedge+2 and retires any delivered entry.
    task automatic sample();
        logic [31:0] e;
        #1;
        if (id_valid && id_ready) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("deliver pc=%h ir=%h expected_pc=%h", id_pc, id_ir, e);
                chk("deliver_pc", id_pc, e);
                chk("deliver_ir", id_ir, memf(e));
                delivered++;
            end
        end
        if (id2_valid && id2_ready) begin
            chk("sb2_has_entry", 32'(sb2.size() != 0), 32'd1);
            if (sb2.size() != 0) begin
                e = sb2.pop_front();
                $display("deliver2 pc=%h ir=%h expected_pc=%h", id2_pc, id2_ir, e);
                chk("wrap_pc", id2_pc, e);
                chk("wrap_ir", id2_ir, memf(e));
                delivered2++;
            end
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            next();
        end
    endtask

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        reset2_n = 1'b0; redirect2 = 1'b0; redirect2_pc = '0; id2_ready = 1'b1;
        next();
        next();

        // Reset state
        sample();
        chk("rst_imem_rd", 32'(imem_rd), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        next();

        // Release reset: c0 issue, c2 first delivery
        sb_restart(32'h0);
        reset_n = 1'b1;
        sample();
        chk("c0_imem_rd", 32'(imem_rd), 32'd1);
        chk("c0_imem_addr", imem_addr, 32'h0);
        chk("c0_id_valid", 32'(id_valid), 32'd0);
        next();
        sample();
        chk("c1_id_valid", 32'(id_valid), 32'd0);
        chk("c1_imem_addr", imem_addr, 32'h4);
        next();
        sample();
        chk("c2_id_valid", 32'(id_valid), 32'd1);
        chk("c2_id_pc", id_pc, 32'h0);
        next();
        d0 = delivered;
        run(6);
        chk("seq_rate", 32'(delivered - d0), 32'd6);

        // Stall: fills to DEPTH, issue stops when count+inflight reaches 4
        id_ready = 1'b0;
        sample();
        chk("s0_q_count", 32'(q_count), 32'd1);
        chk("s0_imem_rd", 32'(imem_rd), 32'd1);
        next();
        sample();
        chk("s1_imem_rd", 32'(imem_rd), 32'd1);
        next();
        sample();
        chk("s2_imem_rd", 32'(imem_rd), 32'd0);
        next();
        for (int i = 3; i < 10; i++) begin
            sample();
            chk("stall_imem_rd", 32'(imem_rd), 32'd0);
            chk("stall_q_count", 32'(q_count), 32'd4);
            chk("stall_valid", 32'(id_valid), 32'd1);
            chk("stall_hold_pc", id_pc, sb[0]);
            next();
        end
        id_ready = 1'b1;
        sample();
        chk("r0_imem_rd", 32'(imem_rd), 32'd0);
        next();
        sample();
        chk("r1_imem_rd", 32'(imem_rd), 32'd1);
        next();
        d0 = delivered;
        run(10);
        chk("release_rate", 32'(delivered - d0), 32'd10);

        // Redirect to 0x200 while streaming
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        sample();
        chk("rdr_id_valid", 32'(id_valid), 32'd0);
        chk("rdr_imem_rd", 32'(imem_rd), 32'd0);
        sb_restart(32'h0000_0200);
        next();
        redirect = 1'b0;
        sample();
        chk("t1_imem_addr", imem_addr, 32'h200);
        chk("t1_imem_rd", 32'(imem_rd), 32'd1);
        chk("t1_q_count", 32'(q_count), 32'd0);
        chk("t1_id_valid", 32'(id_valid), 32'd0);
        next();
        sample();
        chk("t2_id_valid", 32'(id_valid), 32'd0);
        next();
        sample();
        chk("t3_id_valid", 32'(id_valid), 32'd1);
        chk("t3_id_pc", id_pc, 32'h200);
        next();
        run(8);

        // Misaligned redirect with a full queue under stall
        id_ready = 1'b0;
        run(6);
        sample();
        chk("full_q_count", 32'(q_count), 32'd4);
        next();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        sample();
        chk("rdr2_id_valid", 32'(id_valid), 32'd0);
        sb_restart(32'h0000_0200);
        next();
        redirect = 1'b0;
        id_ready = 1'b1;
        sample();
        chk("mis_q_count", 32'(q_count), 32'd0);
        chk("mis_imem_addr", imem_addr, 32'h200);
        chk("mis_imem_rd", 32'(imem_rd), 32'd1);
        next();
        sample();
        next();
        sample();
        chk("mis_t3_valid", 32'(id_valid), 32'd1);
        chk("mis_t3_pc", id_pc, 32'h200);
        next();
        run(6);

        // Reset mid-run with a full queue
        id_ready = 1'b0;
        run(6);
        sample();
        chk("full2_q_count", 32'(q_count), 32'd4);
        next();
        reset_n = 1'b0;
        sample();
        chk("rstm_id_valid", 32'(id_valid), 32'd0);
        chk("rstm_imem_rd", 32'(imem_rd), 32'd0);
        next();
        reset_n = 1'b1;
        id_ready = 1'b1;
        sb_restart(32'h0);
        sample();
        chk("rstm_c0_q_count", 32'(q_count), 32'd0);
        chk("rstm_c0_valid", 32'(id_valid), 32'd0);
        chk("rstm_c0_addr", imem_addr, 32'h0);
        chk("rstm_c0_rd", 32'(imem_rd), 32'd1);
        next();
        d0 = delivered;
        run(10);
        chk("rstm_rate", 32'(delivered - d0), 32'd9);

        // PC wrap from RESET_VEC = FFFF_FFF8
        sb2_restart(32'hFFFF_FFF8);
        reset2_n = 1'b1;
        run(8);
        chk("wrap_count", 32'(delivered2), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
